// File: rtl/aimbot_pkg.sv
// Shared tile geometry and index-width helpers for the bin window path.
package aimbot_pkg;

   localparam int unsigned COMP_WIDTH  = 8;
   localparam int unsigned COMP_HEIGHT = 10;
   localparam int unsigned SUM_W       = 7;
   localparam int unsigned PART_W      = 4;

   // Index width that never collapses to zero bits for single-entry ranges.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned tile_x_w(input int unsigned h_act);
      return idx_w(h_act / COMP_WIDTH);
   endfunction

   function automatic int unsigned tile_y_w(input int unsigned v_act);
      return idx_w(v_act / COMP_HEIGHT);
   endfunction

endpackage

// File: rtl/tile_accum_ram.sv
// Per-tile-column vertical hit accumulator: combinational read, registered write.
module tile_accum_ram
   import aimbot_pkg::*;
#(
   parameter int unsigned DEPTH = 160,
   parameter int unsigned AW    = 8,
   parameter int unsigned DW    = SUM_W
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];

   // Contents need no reset: the first line of every tile row overwrites.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pixel_compressor.sv
// Classifies pixels against a colour box and emits one binary bin per 8x10 tile.
module pixel_compressor
   import aimbot_pkg::*;
#(
   parameter int unsigned H_ACT       = 1280,
   parameter int unsigned V_ACT       = 720,
   parameter logic [7:0]  R_MIN       = 8'd160,
   parameter logic [7:0]  G_MAX       = 8'd96,
   parameter logic [7:0]  B_MAX       = 8'd96,
   parameter int unsigned TILE_THRESH = 40,
   localparam int unsigned XW  = $clog2(H_ACT),
   localparam int unsigned TXW = tile_x_w(H_ACT),
   localparam int unsigned TYW = tile_y_w(V_ACT)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           vsync,
   input  logic           de,
   input  logic [7:0]     r,
   input  logic [7:0]     g,
   input  logic [7:0]     b,
   input  logic [XW-1:0]  x,
   output logic           valid,
   output logic           bin,
   output logic           cls,
   output logic [TXW-1:0] tile_x,
   output logic [TYW-1:0] tile_y
);

   localparam int unsigned CB  = $clog2(COMP_WIDTH);
   localparam int unsigned LW  = $clog2(COMP_HEIGHT);
   localparam int unsigned NTX = H_ACT / COMP_WIDTH;
   localparam int unsigned NTY = V_ACT / COMP_HEIGHT;

   logic              r_hit1, r_de1;
   logic [XW-1:0]     r_x1;
   logic [PART_W-1:0] r_part2;
   logic              r_done2, r_de2;
   logic [TXW-1:0]    r_tx2;
   logic              r_v3;
   logic [SUM_W-1:0]  r_sum3;
   logic [TXW-1:0]    r_tx3;
   logic [TYW-1:0]    r_ty3;
   logic              r_vs_d;
   logic [LW-1:0]     r_line;
   logic [TYW-1:0]    r_row;

   logic              w_vs_rise, w_de_fall, w_first_px, w_last_px, w_last_line;
   logic [SUM_W-1:0]  w_rdata, w_sum;

   assign w_vs_rise   = vsync & ~r_vs_d;
   // de fall seen at the S3 stage so the column in flight still uses the old line count.
   assign w_de_fall   = r_de2 & ~r_de1;
   assign w_first_px  = (r_x1[CB-1:0] == CB'(0));
   assign w_last_px   = (r_x1[CB-1:0] == CB'(COMP_WIDTH - 1));
   assign w_last_line = (r_line == LW'(COMP_HEIGHT - 1));
   assign w_sum       = (r_line == '0) ? SUM_W'(r_part2) : w_rdata + SUM_W'(r_part2);

   tile_accum_ram #(.DEPTH(NTX), .AW(TXW), .DW(SUM_W)) u_ram (
      .clk     (clk),
      .i_we    (r_done2),
      .i_waddr (r_tx2),
      .i_wdata (w_sum),
      .i_raddr (r_tx2),
      .o_rdata (w_rdata)
   );

   // S1 classify, S2 horizontal partial, S3 vertical accumulate, then output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hit1  <= 1'b0;
         r_de1   <= 1'b0;
         r_x1    <= '0;
         r_part2 <= '0;
         r_done2 <= 1'b0;
         r_de2   <= 1'b0;
         r_tx2   <= '0;
         r_v3    <= 1'b0;
         r_sum3  <= '0;
         r_tx3   <= '0;
         r_ty3   <= '0;
      end else begin
         r_hit1  <= de & (r >= R_MIN) & (g <= G_MAX) & (b <= B_MAX);
         r_de1   <= de;
         r_x1    <= x;
         r_de2   <= r_de1;
         r_done2 <= r_de1 & w_last_px;
         r_tx2   <= TXW'(r_x1 >> CB);
         if (w_vs_rise)
            r_part2 <= '0;
         else if (r_de1)
            r_part2 <= w_first_px ? PART_W'(r_hit1) : r_part2 + PART_W'(r_hit1);
         r_v3    <= r_done2 & w_last_line;
         r_sum3  <= w_sum;
         r_tx3   <= r_tx2;
         r_ty3   <= r_row;
      end
   end

   // Line-in-tile and tile-row counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_line <= '0;
         r_row  <= '0;
      end else if (w_vs_rise) begin
         r_line <= '0;
         r_row  <= '0;
      end else if (w_de_fall) begin
         if (w_last_line) begin
            r_line <= '0;
            r_row  <= (r_row == TYW'(NTY - 1)) ? '0 : r_row + TYW'(1);
         end else begin
            r_line <= r_line + LW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vs_d <= 1'b0;
         valid  <= 1'b0;
         bin    <= 1'b0;
         cls    <= 1'b0;
         tile_x <= '0;
         tile_y <= '0;
      end else begin
         r_vs_d <= vsync;
         cls    <= w_vs_rise;
         valid  <= r_v3;
         if (r_v3) begin
            bin    <= (r_sum3 >= SUM_W'(TILE_THRESH));
            tile_x <= r_tx3;
            tile_y <= r_ty3;
         end else begin
            bin    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pixel_compressor.sv
// Directed bench for pixel_compressor on a reduced 32x20 frame (4x2 tiles).
module tb_pixel_compressor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vsync = 1'b0;
   logic       de = 1'b0;
   logic [7:0] r = 8'd0, g = 8'd0, b = 8'd0;
   logic [4:0] x = 5'd0;
   logic       valid, bin, cls;
   logic [1:0] tile_x;
   logic [0:0] tile_y;

   pixel_compressor #(.H_ACT(32), .V_ACT(20), .R_MIN(8'd160), .G_MAX(8'd96),
                      .B_MAX(8'd96), .TILE_THRESH(40)) dut (
      .clk(clk), .rst(rst), .vsync(vsync), .de(de), .r(r), .g(g), .b(b), .x(x),
      .valid(valid), .bin(bin), .cls(cls), .tile_x(tile_x), .tile_y(tile_y)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe recorder.
   int   n_v = 0, n_cls = 0;
   logic rec_bin [512];
   int   rec_tx [512], rec_ty [512], rec_cyc [512];
   always @(negedge clk) begin
      if (valid) begin
         if (n_v < 512) begin
            rec_bin[n_v] <= bin;
            rec_tx[n_v]  <= int'(tile_x);
            rec_ty[n_v]  <= int'(tile_y);
            rec_cyc[n_v] <= cyc;
         end
         n_v <= n_v + 1;
      end
      if (cls) n_cls <= n_cls + 1;
   end

   int          n_checks = 0, n_err = 0;
   int          t_mark = 0;
   logic [31:0] lmask [20];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      de = 1'b0; x = 5'd0; r = 8'd0; g = 8'd0; b = 8'd0;
      repeat (n) @(negedge clk);
   endtask

   task automatic vs_pulse();
      vsync = 1'b1; de = 1'b0;
      @(negedge clk);
      chk("cls_pulse", 32'(cls), 32'd1);
      @(negedge clk);
      chk("cls_one_cycle", 32'(cls), 32'd0);
      vsync = 1'b0;
      idle(3);
   endtask

   task automatic line(input logic [31:0] mask, input int li,
                       input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb);
      for (int xx = 0; xx < 32; xx++) begin
         de = 1'b1;
         x  = 5'(xx);
         if (mask[xx]) begin r = cr; g = cg; b = cb; end
         else begin r = 8'd0; g = 8'd0; b = 8'd0; end
         if (li == 9 && xx == 7) t_mark = cyc;
         @(negedge clk);
      end
      idle(4);
   endtask

   task automatic run_frame(input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb);
      vs_pulse();
      for (int l = 0; l < 20; l++) line(lmask[l], l, cr, cg, cb);
      idle(8);
   endtask

   task automatic set_mask(input int lo, input int hi, input logic [31:0] m);
      for (int l = 0; l < 20; l++) lmask[l] = (l >= lo && l <= hi) ? m : 32'd0;
   endtask

   // Expect 8 strobes in raster order; exp bit i is the bin of tile (i%4, i/4).
   task automatic check_frame(input int base, input logic [7:0] exp, input string tag);
      chk($sformatf("%s_count", tag), 32'(n_v - base), 32'd8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s_bin%0d", tag, i), 32'(rec_bin[base + i]), 32'(exp[i]));
         chk($sformatf("%s_tx%0d", tag, i), 32'(rec_tx[base + i]), 32'(i % 4));
         chk($sformatf("%s_ty%0d", tag, i), 32'(rec_ty[base + i]), 32'(i / 4));
      end
   endtask

   initial begin
      int base, cbase;
      repeat (3) @(negedge clk);
      // Reset held with live traffic.
      for (int i = 0; i < 20; i++) begin
         de = 1'b1; x = 5'(i); r = 8'd255; g = 8'd0; b = 8'd0;
         vsync = (i == 5);
         @(negedge clk);
      end
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_bin", 32'(bin), 32'd0);
      chk("rst_cls", 32'(cls), 32'd0);
      chk("rst_tile_x", 32'(tile_x), 32'd0);
      chk("rst_tile_y", 32'(tile_y), 32'd0);
      chk("rst_no_strobe", 32'(n_v), 32'd0);
      chk("rst_no_cls", 32'(n_cls), 32'd0);
      vsync = 1'b0;
      idle(1);
      rst = 1'b0;
      idle(2);

      // Black frame.
      base = n_v; cbase = n_cls;
      set_mask(0, 19, 32'd0);
      run_frame(8'd0, 8'd0, 8'd0);
      check_frame(base, 8'h00, "black");
      chk("black_cls", 32'(n_cls - cbase), 32'd1);

      // Full red frame plus first-strobe latency.
      base = n_v;
      set_mask(0, 19, 32'hFFFF_FFFF);
      run_frame(8'd255, 8'd0, 8'd0);
      check_frame(base, 8'hFF, "red");
      chk("red_latency", 32'(rec_cyc[base]), 32'(t_mark + 4));

      // Threshold edge on tile (0,0): 40 hits then 39 hits.
      base = n_v;
      set_mask(0, 4, 32'h0000_00FF);
      run_frame(8'd255, 8'd0, 8'd0);
      check_frame(base, 8'h01, "th40");
      base = n_v;
      lmask[4] = 32'h0000_007F;
      run_frame(8'd255, 8'd0, 8'd0);
      check_frame(base, 8'h00, "th39");

      // Colour box bounds on tile (0,0).
      set_mask(0, 9, 32'h0000_00FF);
      base = n_v;
      run_frame(8'd160, 8'd96, 8'd96);
      check_frame(base, 8'h01, "col_edge");
      base = n_v;
      run_frame(8'd159, 8'd96, 8'd96);
      check_frame(base, 8'h00, "col_r159");
      base = n_v;
      run_frame(8'd160, 8'd97, 8'd96);
      check_frame(base, 8'h00, "col_g97");
      base = n_v;
      run_frame(8'd160, 8'd96, 8'd97);
      check_frame(base, 8'h00, "col_b97");

      // Row 1 must not inherit row 0 counts.
      base = n_v;
      set_mask(0, 9, 32'hFFFF_FFFF);
      run_frame(8'd255, 8'd0, 8'd0);
      check_frame(base, 8'h0F, "overwrite");

      // vsync after line 5 restarts the tile grid.
      base = n_v; cbase = n_cls;
      vs_pulse();
      for (int l = 0; l < 6; l++) line(32'hFFFF_FFFF, l, 8'd255, 8'd0, 8'd0);
      chk("midvs_no_early", 32'(n_v - base), 32'd0);
      vs_pulse();
      for (int l = 0; l < 10; l++) line(32'hFFFF_FFFF, 100 + l, 8'd255, 8'd0, 8'd0);
      for (int l = 0; l < 10; l++) line(32'd0, 100 + l, 8'd0, 8'd0, 8'd0);
      idle(8);
      check_frame(base, 8'h0F, "midvs");
      chk("midvs_cls", 32'(n_cls - cbase), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/pixel_compressor.md
# pixel_compressor

Upstream stage of the bin window path. Classifies each active HDMI pixel against a target-colour box, counts hits inside every COMP_WIDTH×COMP_HEIGHT tile (8×10), and emits one binary bin per tile in raster order. Its valid/bin/cls stream drives `bin_buffer`, which supplies column windows to the compressed-window detector.

## Interface
- H_ACT, 1280: active pixels per line; must be a multiple of COMP_WIDTH
- V_ACT, 720: active lines per frame; must be a multiple of COMP_HEIGHT
- R_MIN, 8'd160: pixel hit requires r ≥ R_MIN
- G_MAX, 8'd96: pixel hit requires g ≤ G_MAX
- B_MAX, 8'd96: pixel hit requires b ≤ B_MAX
- TILE_THRESH, 40: tile bin = 1 when hit count ≥ TILE_THRESH (range 1..80)
- clk  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- vsync  in  1  frame sync, active high
- de  in  1  active-video qualifier
- r, g, b  in  8 each  pixel colour
- x  in  $clog2(H_ACT)  pixel column, valid while de
- valid  out  1  one-cycle strobe: bin is a finished tile
- bin  out  1  tile result
- cls  out  1  one-cycle strobe: new frame, clear consumer
- tile_x  out  $clog2(H_ACT/8)  tile column of current bin (debug/verification)
- tile_y  out  $clog2(V_ACT/10)  tile row of current bin

## Operation
- S1 (classify): register hit = de & (r≥R_MIN) & (g≤G_MAX) & (b≤B_MAX), plus de, x.
- S2 (horizontal): 4-bit partial; at x[2:0]==0 load hit, else add hit. At x[2:0]==7 with de, flag tile-column complete, tile index = x>>3.
- S3 (vertical): accumulator RAM, H_ACT/8 entries × 7 bits. On tile-column complete: if line_in_tile==0 write partial (overwrite), else write acc+partial. If line_in_tile==9, compare acc+partial ≥ TILE_THRESH → drive valid=1, bin, tile_x, tile_y.
- Line counters: line_in_tile (0..9) and tile_row (0..V_ACT/10−1) advance on falling edge of de; line_in_tile wraps 9→0 incrementing tile_row. Both reset to 0 on rising edge of vsync.
- cls: one-cycle pulse registered from vsync rising edge.
- Each RAM entry is touched once per 8 cycles; no read-after-write hazard logic required.
- Sum width: 7 bits (max 80); no saturation needed.

## Timing
- Reset: valid=0, bin=0, cls=0, tile_x=0, tile_y=0; counters, partial, pipeline regs = 0. RAM contents need no reset (first line of each tile row overwrites).
- Latency: valid asserts 3 cycles after the clk edge sampling the pixel with x[2:0]==7 on line_in_tile==9.
- cls asserts 1 cycle after vsync rising edge is sampled.
- Output order per frame: cls, then H_ACT/8 × V_ACT/10 valid strobes in raster order, at most one per 8 cycles.
- de drop mid-tile: partial retains; the tile completes only at x[2:0]==7 with de. Incomplete trailing tile never strobes.
- vsync mid-frame: counters reset, cls pulses, partial cleared; in-flight S3 result still emits.
- rst mid-frame: all state cleared immediately; nothing emitted until next de with line counters at 0.
- valid and cls simultaneous: impossible in legal timing (de low in vsync); if forced, both assert.

## Structure
- Shared package `aimbot_pkg`: COMP_WIDTH=8, COMP_HEIGHT=10 (also used by `bin_buffer`/window stages), tile index width functions.
- One sub-module: `tile_accum_ram` (H_ACT/8 × 7-bit, one read, one write port, combinational read, registered write).

## Test plan
- Reset: rst=1 with traffic → all outputs 0; release rst, one frame of black → cls once, 11520 valid strobes, all bin=0.
- Full-red frame (r=255,g=0,b=0) → every bin=1; first valid 3 cycles after x=7 of line 9; tile_x=0, tile_y=0.
- Threshold edge: tile(0,0) with exactly 40 hits → bin=1; with 39 hits → bin=0; TILE_THRESH=40.
- Colour bounds: r=160,g=96,b=96 → hit; r=159 or g=97 or b=97 → no hit (single tile fully one colour checks 80 vs 0).
- Line overwrite: tile row 0 all hits, tile row 1 zero hits → row 1 bins all 0 (no carryover).
- Mid-frame vsync after line 5 → cls pulse, counters 0, next tile row emitted after 10 further lines; no spurious valid.
